rom_seq: RTL
============

ROM_SEQ -- requirements
Module: rom_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, ROM byte-address width (legal range 9..16).
REQ-002 SHALL have parameter LD_BASE, default 256, ROM byte offset added to every LD pointer.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to run the program from address 0.
REQ-006 SHALL have port rom_addr  output  ADDR_W  ROM byte address; this is the registered program pointer.
REQ-007 SHALL have port rom_data  input  8  synchronous ROM data: value at cycle t+1 = ROM[rom_addr at cycle t].
REQ-008 SHALL have port tx_data  output  8  byte offered to the UART.
REQ-009 SHALL have port tx_wr  output  1  one-cycle UART write strobe.
REQ-010 SHALL have port tx_busy  input  1  UART busy; no write is issued while this is high.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when HALT executes.
REQ-013 SHALL have port err  output  1  sticky flag for an invalid opcode; cleared by the next accepted start.

Function
REQ-014 SHALL hold four 8-bit registers r0..r3; all arithmetic is modulo 256 (DEC 00->FF, INC FF->00, ADD wraps).
REQ-015 SHALL implement states IDLE, FETCH, DECODE, IMM_LO, IMM_HI, TX_WAIT, TX_END, LD_DATA; FETCH is a one-cycle ROM wait that then enters a recorded consumer state.
REQ-016 SHALL accept start only in IDLE: ptr<=0, err<=0, then FETCH->DECODE; start while busy SHALL be ignored.
REQ-017 SHALL increment ptr by one for every byte consumed; ptr wraps from 2^ADDR_W-1 to 0.
REQ-018 SHALL decode 00 HALT: done=1 for one cycle, return to IDLE.
REQ-019 SHALL decode 01 lo hi JUMP: ptr<={hi,lo} truncated to ADDR_W; takes 6 cycles from DECODE to the next DECODE.
REQ-020 SHALL decode 04-07 MOV r[op1:0],imm; takes 4 cycles.
REQ-021 SHALL decode 08-0B SEND r[op1:0]: tx_data latched in DECODE; wait in TX_WAIT while tx_busy=1; tx_wr=1 for exactly one cycle in TX_END; then FETCH; takes 4 cycles when tx_busy=0.
REQ-022 SHALL decode 0C-0F DEC, 18-1B INC, and 80-8F ADD r[op3:2]+=r[op1:0]; each takes 2 cycles; ADD rx,rx doubles rx.
REQ-023 SHALL decode 10-13 r lo hi JNZ: jump if r[op1:0]!=0, else fall through past both immediate bytes; takes 6 cycles.
REQ-024 SHALL decode C0-CF LD r[op3:2]: p=op[1]; address = (LD_BASE + {r[2p+1],r[2p]}) mod 2^ADDR_W.
REQ-025 SHALL, for LD, save the return pointer (ptr+1), fetch the data byte, write it in LD_DATA, restore the pointer; LD takes 4 cycles.
REQ-026 SHALL treat any other opcode as invalid: err<=1, return to IDLE, no register write and no tx_wr.
REQ-027 SHALL make register reads during DECODE see values written by the previous instruction.

Reset
REQ-028 SHALL, on reset, immediately force state=IDLE, ptr=0, r0..r3=0, tx_data=0, tx_wr=0, done=0, err=0, busy=0, including in the middle of an operation.
REQ-029 SHALL have no reset-release side effects: no tx_wr and no done pulse until a start is accepted.

Structure
REQ-030 SHALL put the opcode constants and the state enumeration in a shared package rom_seq_pkg.
REQ-031 SHALL implement the register file (4x8, one write port, two read ports) as sub-module rom_seq_regs; all other logic stays in rom_seq.

Verification
REQ-032 SHALL verify: reset asserted mid-SEND -> tx_wr, busy and err all 0 in the same cycle; r0..r3 read 0.
REQ-033 SHALL verify: ROM 04 41 08 00 with start -> exactly one tx_wr with tx_data=0x41, then done pulse, err=0.
REQ-034 SHALL verify: ROM 04 03 05 30 09 19 0C 10 04 00 00 -> tx bytes 0x30, 0x31, 0x32, then done.
REQ-035 SHALL verify: with ADDR_W=10, LD_BASE=0x200 and ROM 06 34 07 01 C2 08 00, ROM[0x334]=0x5A -> sends 0x5A.
REQ-036 SHALL verify: ROM[0]=FF -> err=1, busy=0, no tx_wr; the next start clears err.
REQ-037 SHALL verify: tx_busy held high for 100 cycles during SEND -> no tx_wr; on release exactly one pulse; a start pulsed meanwhile is ignored.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg: shared definitions for the ROM-driven UART sequencer.
//   state_t     - sequencer FSM states
//   op_class_t  - decoded instruction class
//   OPC_*       - opcode constants / opcode-group prefixes
//   op_class()  - maps a raw opcode byte to its instruction class
package rom_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    IMM_LO,
    IMM_HI,
    TX_WAIT,
    TX_END,
    LD_DATA
  } state_t;

  typedef enum logic [3:0] {
    OP_HALT,
    OP_JUMP,
    OP_MOV,
    OP_SEND,
    OP_DEC,
    OP_INC,
    OP_ADD,
    OP_JNZ,
    OP_LD,
    OP_BAD
  } op_class_t;

  localparam logic [7:0] OPC_HALT = 8'h00;
  localparam logic [7:0] OPC_JUMP = 8'h01;
  // Register-indexed groups: the low two bits select the register.
  localparam logic [5:0] OPC_MOV  = 6'b0000_01;  // 04-07
  localparam logic [5:0] OPC_SEND = 6'b0000_10;  // 08-0B
  localparam logic [5:0] OPC_DEC  = 6'b0000_11;  // 0C-0F
  localparam logic [5:0] OPC_JNZ  = 6'b0001_00;  // 10-13
  localparam logic [5:0] OPC_INC  = 6'b0001_10;  // 18-1B
  // Two-register groups: op[3:2] and op[1:0] are operands.
  localparam logic [3:0] OPC_ADD  = 4'h8;        // 80-8F
  localparam logic [3:0] OPC_LD   = 4'hC;        // C0-CF

  function automatic op_class_t op_class(input logic [7:0] op);
    op_class_t c;
    c = OP_BAD;
    if (op == OPC_HALT)             c = OP_HALT;
    else if (op == OPC_JUMP)        c = OP_JUMP;
    else if (op[7:2] == OPC_MOV)    c = OP_MOV;
    else if (op[7:2] == OPC_SEND)   c = OP_SEND;
    else if (op[7:2] == OPC_DEC)    c = OP_DEC;
    else if (op[7:2] == OPC_JNZ)    c = OP_JNZ;
    else if (op[7:2] == OPC_INC)    c = OP_INC;
    else if (op[7:4] == OPC_ADD)    c = OP_ADD;
    else if (op[7:4] == OPC_LD)     c = OP_LD;
    return c;
  endfunction

endpackage

// File: rtl/rom_seq_if.sv
// rom_seq_if: ROM read port and UART write port of the sequencer.
//   rom_addr  - ROM byte address (sequencer -> ROM)
//   rom_data  - ROM data, one cycle after rom_addr (ROM -> sequencer)
//   tx_data   - byte offered to the UART
//   tx_wr     - one-cycle UART write strobe
//   tx_busy   - UART busy; no write while high
// master = sequencer side, slave = ROM/UART side.
interface rom_seq_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_busy;

  modport master (
    output rom_addr, tx_data, tx_wr,
    input  rom_data, tx_busy
  );

  modport slave (
    input  rom_addr, tx_data, tx_wr,
    output rom_data, tx_busy
  );
endinterface

// File: rtl/rom_seq_regs.sv
// rom_seq_regs: 4 x 8-bit register file r0..r3.
//   clk, reset         - clock, asynchronous active-high reset (clears all regs)
//   we, waddr, wdata   - single write port, takes effect at the rising edge
//   raddr_a/b, rdata_a/b - two combinational read ports
module rom_seq_regs (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);
  logic [3:0][7:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
endmodule

// File: rtl/rom_seq.sv
// rom_seq: tiny byte-code sequencer that runs a program out of a synchronous
// ROM and pushes bytes to a UART.
//   clk, reset - clock, asynchronous active-high reset
//   start      - one-cycle request to run from address 0 (honoured only in IDLE)
//   bus        - rom_seq_if master: ROM address/data, UART tx_data/tx_wr/tx_busy
//   busy       - high whenever the FSM is not IDLE
//   done       - one-cycle pulse after HALT executes
//   err        - sticky invalid-opcode flag, cleared by the next accepted start
module rom_seq
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int LD_BASE = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  rom_seq_if.master     bus,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t            state_q, state_d;
  state_t            nxt_q, nxt_d;      // consumer state entered after FETCH
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ret_q, ret_d;      // LD return pointer
  logic [7:0]        op_q, op_d;
  logic [7:0]        lo_q, lo_d;        // low jump-target byte
  logic              take_q, take_d;    // jump taken at IMM_HI
  logic [7:0]        tx_data_q, tx_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              rf_we;
  logic [1:0]        rf_waddr, rf_raddr_a, rf_raddr_b;
  logic [7:0]        rf_wdata, rf_rdata_a, rf_rdata_b;

  op_class_t         cls, op_q_cls;
  logic [ADDR_W-1:0] ptr_inc, ld_addr;

  assign cls      = op_class(bus.rom_data);
  assign op_q_cls = op_class(op_q);
  assign ptr_inc  = ptr_q + ADDR_W'(1);
  // LD reads the register pair {r[2p+1], r[2p]} through ports A (high) and B (low).
  assign ld_addr  = ADDR_W'(LD_BASE) + ADDR_W'({rf_rdata_a, rf_rdata_b});

  always_comb begin
    // Read ports are addressed straight from the opcode on rom_data so the
    // DECODE cycle sees the register file contents directly.
    rf_raddr_a = bus.rom_data[1:0];
    rf_raddr_b = bus.rom_data[3:2];
    if (cls == OP_LD) begin
      rf_raddr_a = {bus.rom_data[1], 1'b1};
      rf_raddr_b = {bus.rom_data[1], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    ptr_d     = ptr_q;
    ret_d     = ret_q;
    op_d      = op_q;
    lo_d      = lo_q;
    take_d    = take_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rf_we     = 1'b0;
    rf_waddr  = bus.rom_data[1:0];
    rf_wdata  = bus.rom_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = '0;
          err_d   = 1'b0;
          state_d = FETCH;
          nxt_d   = DECODE;
        end
      end

      FETCH: state_d = nxt_q;

      DECODE: begin
        op_d    = bus.rom_data;
        ptr_d   = ptr_inc;
        state_d = FETCH;
        nxt_d   = DECODE;
        case (cls)
          OP_HALT: begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
          OP_JUMP: begin
            take_d = 1'b1;
            nxt_d  = IMM_LO;
          end
          OP_JNZ: begin
            take_d = (rf_rdata_a != 8'h00);
            nxt_d  = IMM_LO;
          end
          OP_MOV:  nxt_d = IMM_LO;
          OP_SEND: begin
            tx_data_d = rf_rdata_a;
            state_d   = TX_WAIT;
          end
          OP_DEC: begin
            rf_we    = 1'b1;
            rf_wdata = rf_rdata_a - 8'd1;
          end
          OP_INC: begin
            rf_we    = 1'b1;
            rf_wdata = rf_rdata_a + 8'd1;
          end
          OP_ADD: begin
            rf_we    = 1'b1;
            rf_waddr = bus.rom_data[3:2];
            rf_wdata = rf_rdata_b + rf_rdata_a;
          end
          OP_LD: begin
            ret_d = ptr_inc;
            ptr_d = ld_addr;
            nxt_d = LD_DATA;
          end
          default: begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        endcase
      end

      IMM_LO: begin
        ptr_d   = ptr_inc;
        state_d = FETCH;
        if (op_q_cls == OP_MOV) begin
          rf_we    = 1'b1;
          rf_waddr = op_q[1:0];
          nxt_d    = DECODE;
        end else begin
          lo_d  = bus.rom_data;
          nxt_d = IMM_HI;
        end
      end

      IMM_HI: begin
        ptr_d   = take_q ? ADDR_W'({bus.rom_data, lo_q}) : ptr_inc;
        state_d = FETCH;
        nxt_d   = DECODE;
      end

      TX_WAIT: if (!bus.tx_busy) state_d = TX_END;

      TX_END: begin
        state_d = FETCH;
        nxt_d   = DECODE;
      end

      LD_DATA: begin
        rf_we    = 1'b1;
        rf_waddr = op_q[3:2];
        ptr_d    = ret_q;
        state_d  = FETCH;
        nxt_d    = DECODE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      nxt_q     <= DECODE;
      ptr_q     <= '0;
      ret_q     <= '0;
      op_q      <= '0;
      lo_q      <= '0;
      take_q    <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nxt_q     <= nxt_d;
      ptr_q     <= ptr_d;
      ret_q     <= ret_d;
      op_q      <= op_d;
      lo_q      <= lo_d;
      take_q    <= take_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  rom_seq_regs u_regs (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rf_raddr_a),
    .raddr_b (rf_raddr_b),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b)
  );

  assign bus.rom_addr = ptr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_wr    = (state_q == TX_END);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err          = err_q;

endmodule
